// File: rtl/window_gen_3x3_pkg.sv
// window_gen_pkg: shared constants, tap coordinate type and tap bit-offset helper for window_gen_3x3
package window_gen_pkg;

   localparam int WIN_TAPS = 9;

   typedef struct packed {
      logic [1:0] r;
      logic [1:0] c;
   } tap_coord_t;

   function automatic int tap_lsb(input int r, input int c, input int bus_size);
      return (r * 3 + c) * bus_size;
   endfunction

endpackage

// File: rtl/window_gen_3x3_line_delay_ram.sv
// line_delay_ram: DEPTH-sample EN-gated delay, circular RAM of DEPTH-1 words plus a registered read
module line_delay_ram
   import window_gen_pkg::*;
#(
   parameter int DEPTH    = 640,
   parameter int BUS_SIZE = 25
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                en,
   input  logic [BUS_SIZE-1:0] din,
   output logic [BUS_SIZE-1:0] dout
);

   localparam int D  = DEPTH - 1;
   localparam int AW = (D > 1) ? $clog2(D) : 1;

   logic [BUS_SIZE-1:0] mem [D];
   logic [AW-1:0]       ptr;

   // circular pointer advances once per accepted sample
   always_ff @(posedge clock) begin
      if (reset) ptr <= '0;
      else if (en) ptr <= (ptr == AW'(D - 1)) ? '0 : ptr + AW'(1);
   end

   // read-before-write; the output register supplies the last stage of delay
   always_ff @(posedge clock) begin
      if (en) begin
         mem[ptr] <= din;
         dout     <= mem[ptr];
      end
   end

endmodule

// File: rtl/window_gen_3x3.sv
// window_gen_3x3: 3x3 neighbourhood window generator over an EN-qualified raster stream (optional sof via WINDOW_GEN_FRAME_SYNC_EN)
module window_gen_3x3
   import window_gen_pkg::*;
#(
   parameter int WIDTH    = 640,
   parameter int HEIGHT   = 480,
   parameter int BUS_SIZE = 25
) (
   input  logic                         clock,
   input  logic                         reset,
   input  logic                         EN,
`ifdef WINDOW_GEN_FRAME_SYNC_EN
   input  logic                         sof,
`endif
   input  logic [BUS_SIZE-1:0]          data,
   output logic [WIN_TAPS*BUS_SIZE-1:0] window_out,
   output logic                         window_valid,
   output logic [$clog2(HEIGHT)-1:0]    center_row,
   output logic [$clog2(WIDTH)-1:0]     center_col
);

   localparam int RW = $clog2(HEIGHT);
   localparam int CW = $clog2(WIDTH);

   logic [CW-1:0]       col_in, col_pos, col_nxt;
   logic [RW-1:0]       row_in, row_pos, row_nxt;
   logic                sync, interior;
   logic [BUS_SIZE-1:0] row0, row1;
   logic [BUS_SIZE-1:0] win [3][3];

`ifdef WINDOW_GEN_FRAME_SYNC_EN
   assign sync = sof;
`else
   assign sync = 1'b0;
`endif

   line_delay_ram #(.DEPTH(WIDTH), .BUS_SIZE(BUS_SIZE)) u_line1 (
      .clock(clock), .reset(reset), .en(EN), .din(data), .dout(row1)
   );

   line_delay_ram #(.DEPTH(WIDTH), .BUS_SIZE(BUS_SIZE)) u_line0 (
      .clock(clock), .reset(reset), .en(EN), .din(row1), .dout(row0)
   );

   // position of the pixel on the bus (sof forces origin) and the position that follows it
   always_comb begin
      col_pos  = sync ? '0 : col_in;
      row_pos  = sync ? '0 : row_in;
      col_nxt  = (col_pos == CW'(WIDTH - 1)) ? '0 : col_pos + CW'(1);
      row_nxt  = (col_pos != CW'(WIDTH - 1)) ? row_pos :
                 (row_pos == RW'(HEIGHT - 1)) ? '0 : row_pos + RW'(1);
      interior = !sync && row_pos >= RW'(2) && col_pos >= CW'(2);
   end

   // raster position counters
   always_ff @(posedge clock) begin
      if (reset) begin
         col_in <= '0;
         row_in <= '0;
      end else if (EN) begin
         col_in <= col_nxt;
         row_in <= row_nxt;
      end
   end

   // window shift register: columns move left, newest column enters at c=2
   always_ff @(posedge clock) begin
      if (reset) begin
         for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++)
               win[r][c] <= '0;
      end else if (EN) begin
         for (int r = 0; r < 3; r++)
            for (int c = 0; c < 2; c++)
               win[r][c] <= win[r][c+1];
         win[0][2] <= row0;
         win[1][2] <= row1;
         win[2][2] <= data;
      end
   end

   // valid pulse and centre coordinates, updated only for interior windows
   always_ff @(posedge clock) begin
      if (reset) begin
         window_valid <= 1'b0;
         center_row   <= '0;
         center_col   <= '0;
      end else begin
         window_valid <= EN && interior;
         if (EN && interior) begin
            center_row <= row_pos - RW'(1);
            center_col <= col_pos - CW'(1);
         end
      end
   end

   // flatten the window registers onto the output bus
   always_comb begin
      window_out = '0;
      for (int r = 0; r < 3; r++)
         for (int c = 0; c < 3; c++)
            window_out[tap_lsb(r, c, BUS_SIZE) +: BUS_SIZE] = win[r][c];
   end

endmodule

// File: tb/tb_window_gen_3x3.sv
// tb_window_gen_3x3: randomized and directed bench for window_gen_3x3 against a frame-image reference model
module tb_window_gen_3x3;

   localparam int W = 8;
   localparam int H = 6;
   localparam int B = 8;

   logic           clock = 1'b0;
   logic           reset = 1'b1;
   logic           EN    = 1'b0;
   logic [B-1:0]   data  = '0;
`ifdef WINDOW_GEN_FRAME_SYNC_EN
   logic           sof   = 1'b0;
`endif
   logic [9*B-1:0] window_out;
   logic           window_valid;
   logic [2:0]     center_row, center_col;

   int errors = 0, checks = 0;
   int cnt = 0, pulses = 0, er = 0, ec = 0;
   logic           ev = 1'b0;
   logic [9*B-1:0] ew = '0;
   logic [B-1:0]   img [H][W];

   always #5 clock = ~clock;

   window_gen_3x3 #(.WIDTH(W), .HEIGHT(H), .BUS_SIZE(B)) dut (
      .clock(clock),
      .reset(reset),
      .EN(EN),
`ifdef WINDOW_GEN_FRAME_SYNC_EN
      .sof(sof),
`endif
      .data(data),
      .window_out(window_out),
      .window_valid(window_valid),
      .center_row(center_row),
      .center_col(center_col)
   );

   function automatic logic [B-1:0] px(input int p);
      return B'((p / W) * 16 + p % W);
   endfunction

   task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step(input bit en, input logic [B-1:0] d, input bit s);
      int r, c;
      EN = en;
      data = d;
`ifdef WINDOW_GEN_FRAME_SYNC_EN
      sof = s;
`endif
      @(posedge clock);
      ev = 1'b0;
      if (en) begin
         if (s) cnt = 0;
         r = cnt / W;
         c = cnt % W;
         img[r][c] = d;
         ev = (r >= 2 && c >= 2 && !s);
         if (ev) begin
            er = r - 1;
            ec = c - 1;
            for (int i = 0; i < 3; i++)
               for (int j = 0; j < 3; j++)
                  ew[(i*3+j)*B +: B] = img[r-2+i][c-2+j];
         end
         cnt = (cnt + 1) % (W * H);
      end
      #1;
      chk("valid", window_valid, ev);
      chk("center_row", center_row, er);
      chk("center_col", center_col, ec);
      if (ev) chk("window", window_out, ew);
      if (window_valid) pulses++;
   endtask

   task automatic do_reset(input bit en, input logic [B-1:0] d);
      reset = 1'b1;
      EN = en;
      data = d;
      @(posedge clock);
      cnt = 0; ev = 1'b0; er = 0; ec = 0;
      #1;
      reset = 1'b0;
      chk("rst_valid", window_valid, 0);
      chk("rst_row", center_row, 0);
      chk("rst_col", center_col, 0);
      chk("rst_window", window_out, 0);
   endtask

   // mode 0: coordinate pixels; mode 1: coordinate pixels with random EN gaps; mode 2: random pixels
   task automatic frame(input int mode);
      pulses = 0;
      for (int p = 0; p < W * H; p++) begin
         if (mode == 1)
            while ($urandom_range(0, 2) == 0) step(1'b0, B'($urandom), 1'b0);
         step(1'b1, (mode == 2) ? B'($urandom) : px(p), 1'b0);
         if (mode != 2 && p == 2 * W + 2) begin
            chk("first_row", center_row, 1);
            chk("first_col", center_col, 1);
            chk("first_tap00", window_out[0 +: B], 8'h00);
            chk("first_tap11", window_out[4*B +: B], 8'h11);
            chk("first_tap22", window_out[8*B +: B], 8'h22);
         end
         if (mode != 2 && (p == 3 * W || p == 3 * W + 1)) chk("wrap_novalid", window_valid, 0);
         if (mode != 2 && p == 3 * W + 2) begin
            chk("wrap_valid", window_valid, 1);
            chk("wrap_row", center_row, 2);
            chk("wrap_col", center_col, 1);
            chk("wrap_tap00", window_out[0 +: B], 8'h10);
            chk("wrap_tap22", window_out[8*B +: B], 8'h32);
         end
      end
      chk("pulses_per_frame", pulses, (W - 2) * (H - 2));
   endtask

   initial begin
      int first;
      do_reset(1'b0, '0);
      frame(0);
      frame(1);
      frame(2);
      frame(0);
      for (int p = 0; p < 3 * W + 4; p++) step(1'b1, px(p), 1'b0);
      do_reset(1'b1, 8'h34);
      first = 0;
      for (int k = 0; k < W * H; k++) begin
         step(1'b1, px(k), 1'b0);
         if (window_valid && first == 0) first = k + 1;
      end
      chk("first_valid_after_reset", first, 19);
`ifdef WINDOW_GEN_FRAME_SYNC_EN
      for (int p = 0; p < 4 * W + 3; p++) step(1'b1, px(p), 1'b0);
      step(1'b1, 8'h43, 1'b1);
      chk("sof_novalid", window_valid, 0);
      first = 0;
      for (int k = 1; k < W * H; k++) begin
         step(1'b1, px(k), 1'b0);
         if (window_valid && first == 0) begin
            first = k;
            chk("sof_row", center_row, 1);
            chk("sof_col", center_col, 1);
         end
      end
      chk("sof_first_valid", first, 18);
`endif
      frame(1);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
